// File: rtl/fitness_eval_sched.sv
// Fitness evaluation scheduler: walks a population through one shared evaluator,
// writes each fitness back and tracks the minimum-energy individual of the run.
module fitness_eval_sched #(
    parameter int unsigned NUM_PARTICLE_TYPE = 3,
    parameter int unsigned DATA_WIDTH        = 4,
    parameter int unsigned LATTICE_LENGTH    = 11,
    parameter int unsigned SELF_FIT_LENGTH   = 10,
    parameter int unsigned POP_SIZE          = 8,
    parameter int unsigned IDX_WIDTH         = 3,
    parameter int unsigned TIMEOUT           = 64,
    parameter int unsigned SE_W              = NUM_PARTICLE_TYPE * DATA_WIDTH,
    parameter int unsigned IM_W              = NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE * DATA_WIDTH,
    parameter int unsigned IND_W             = LATTICE_LENGTH * DATA_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [IDX_WIDTH:0]         pop_count_i,
    input  logic [SE_W-1:0]            self_energy_vec_i,
    input  logic [IM_W-1:0]            interact_matrix_i,
    output logic                       ind_rd_en_o,
    output logic [IDX_WIDTH-1:0]       ind_rd_addr_o,
    input  logic [IND_W-1:0]           ind_rd_data_i,
    output logic                       eval_in_valid_o,
    output logic [SE_W-1:0]            eval_self_energy_o,
    output logic [IM_W-1:0]            eval_interact_o,
    output logic [IND_W-1:0]           eval_individual_o,
    input  logic                       eval_out_valid_i,
    input  logic [SELF_FIT_LENGTH-1:0] eval_fit_i,
    output logic                       fit_wr_en_o,
    output logic [IDX_WIDTH-1:0]       fit_wr_addr_o,
    output logic [SELF_FIT_LENGTH-1:0] fit_wr_data_o,
    output logic [SELF_FIT_LENGTH-1:0] best_fit_o,
    output logic [IDX_WIDTH-1:0]       best_idx_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);

    localparam int unsigned CW = IDX_WIDTH + 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        StIdle, StFetch, StWaitRd, StIssue, StWaitEval, StWrite, StDone
    } state_e;

    state_e                     state_q, state_d;
    logic [IDX_WIDTH-1:0]       idx_q, idx_d, best_idx_q, best_idx_d;
    logic [CW-1:0]              count_q, count_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic [SELF_FIT_LENGTH-1:0] fit_q, fit_d, best_fit_q, best_fit_d;
    logic                       err_q, err_d, empty_q, empty_d;
    logic [SE_W-1:0]            se_q, se_d;
    logic [IM_W-1:0]            im_q, im_d;
    logic [IND_W-1:0]           ind_q, ind_d;

    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            best_idx_q <= '0;
            count_q    <= '0;
            timer_q    <= '0;
            fit_q      <= '0;
            best_fit_q <= '1;
            err_q      <= 1'b0;
            empty_q    <= 1'b0;
            se_q       <= '0;
            im_q       <= '0;
            ind_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            fit_q      <= fit_d;
            best_fit_q <= best_fit_d;
            err_q      <= err_d;
            empty_q    <= empty_d;
            se_q       <= se_d;
            im_q       <= im_d;
            ind_q      <= ind_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        best_idx_d = best_idx_q;
        count_d    = count_q;
        timer_d    = timer_q;
        fit_d      = fit_q;
        best_fit_d = best_fit_q;
        err_d      = err_q;
        empty_d    = empty_q;
        se_d       = se_q;
        im_d       = im_q;
        ind_d      = ind_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    best_fit_d = '1;
                    best_idx_d = '0;
                    err_d      = 1'b0;
                    if (pop_count_i == '0) begin
                        // Empty run: straight to completion, never looks busy.
                        empty_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        empty_d = 1'b0;
                        se_d    = self_energy_vec_i;
                        im_d    = interact_matrix_i;
                        count_d = (pop_count_i > CW'(POP_SIZE)) ? CW'(POP_SIZE) : pop_count_i;
                        idx_d   = '0;
                        state_d = StFetch;
                    end
                end
            end
            StFetch:  state_d = StWaitRd;
            StWaitRd: begin
                ind_d   = ind_rd_data_i;
                state_d = StIssue;
            end
            StIssue: begin
                timer_d = '0;
                state_d = StWaitEval;
            end
            StWaitEval: begin
                if (eval_out_valid_i) begin
                    fit_d   = eval_fit_i;
                    state_d = StWrite;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    fit_d   = '1;
                    err_d   = 1'b1;
                    state_d = StWrite;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StWrite: begin
                // Strict compare so ties keep the earlier index.
                if (fit_q < best_fit_q) begin
                    best_fit_d = fit_q;
                    best_idx_d = idx_q;
                end
                if ({1'b0, idx_q} == count_q - CW'(1)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IDX_WIDTH'(1);
                    state_d = StFetch;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign ind_rd_en_o        = (state_q == StFetch);
    assign ind_rd_addr_o      = idx_q;
    assign eval_in_valid_o    = (state_q == StIssue);
    assign eval_self_energy_o = se_q;
    assign eval_interact_o    = im_q;
    assign eval_individual_o  = ind_q;
    assign fit_wr_en_o        = (state_q == StWrite);
    assign fit_wr_addr_o      = idx_q;
    assign fit_wr_data_o      = fit_q;
    assign best_fit_o         = best_fit_q;
    assign best_idx_o         = best_idx_q;
    assign busy_o             = (state_q != StIdle) && !empty_q;
    assign done_o             = (state_q == StDone);
    assign err_o              = err_q;

endmodule

// File: tb/tb_fitness_eval_sched.sv
// Randomised bench for fitness_eval_sched: a per-run timeline model predicts every
// output cycle by cycle; directed runs pin the model with hand-computed values.
module tb_fitness_eval_sched;

    localparam int POP = 8, IW = 3, CW = 4, FW = 10, SE_W = 12, IM_W = 36, IND_W = 44;
    localparam logic [FW-1:0] ONES = '1;

    logic             clk_i = 1'b0, rst_n = 1'b1, start_i = 1'b0;
    logic [CW-1:0]    pop_count_i = '0;
    logic [SE_W-1:0]  self_energy_vec_i = '0;
    logic [IM_W-1:0]  interact_matrix_i = '0;
    logic             ind_rd_en_o, eval_in_valid_o, fit_wr_en_o, busy_o, done_o, err_o;
    logic [IW-1:0]    ind_rd_addr_o, fit_wr_addr_o, best_idx_o;
    logic [IND_W-1:0] ind_rd_data_i = '0, eval_individual_o;
    logic [SE_W-1:0]  eval_self_energy_o;
    logic [IM_W-1:0]  eval_interact_o;
    logic             eval_out_valid_i = 1'b0;
    logic [FW-1:0]    eval_fit_i = '0, fit_wr_data_o, best_fit_o;

    fitness_eval_sched dut (
        .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .pop_count_i(pop_count_i),
        .self_energy_vec_i(self_energy_vec_i), .interact_matrix_i(interact_matrix_i),
        .ind_rd_en_o(ind_rd_en_o), .ind_rd_addr_o(ind_rd_addr_o), .ind_rd_data_i(ind_rd_data_i),
        .eval_in_valid_o(eval_in_valid_o), .eval_self_energy_o(eval_self_energy_o),
        .eval_interact_o(eval_interact_o), .eval_individual_o(eval_individual_o),
        .eval_out_valid_i(eval_out_valid_i), .eval_fit_i(eval_fit_i),
        .fit_wr_en_o(fit_wr_en_o), .fit_wr_addr_o(fit_wr_addr_o), .fit_wr_data_o(fit_wr_data_o),
        .best_fit_o(best_fit_o), .best_idx_o(best_idx_o), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0, n_vec = 0, n_err = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Expected timeline, keyed by cycle number.
    logic [IW-1:0]         p_rd   [int];
    bit                    p_issue[int];
    logic [IW+FW-1:0]      p_wr   [int];
    bit                    p_done [int];
    bit                    p_busy [int];
    logic [IW+FW-1:0]      p_best [int];
    bit                    p_err  [int];
    logic [SE_W+IM_W-1:0]  p_cfg  [int];
    logic [IND_W-1:0]      p_ind  [int];
    bit                    p_we   [int];
    logic [FW-1:0]         d_fit  [int];

    // Expected values of the held outputs.
    logic [FW-1:0]    e_best = ONES;
    logic [IW-1:0]    e_bidx = '0;
    logic             e_err = 1'b0;
    logic [SE_W-1:0]  e_se = '0;
    logic [IM_W-1:0]  e_im = '0;
    logic [IND_W-1:0] e_ind = '0;

    logic [IND_W-1:0] mem [POP];
    bit               rd_pend = 0, start_noise = 0;
    logic [IW-1:0]    rd_a = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_plan();
        p_rd.delete(); p_issue.delete(); p_wr.delete(); p_done.delete(); p_busy.delete();
        p_best.delete(); p_err.delete(); p_cfg.delete(); p_ind.delete(); p_we.delete();
        d_fit.delete();
    endtask

    // Lay out one run: individual i takes 4 + w cycles, w = wait cycles for its result.
    function automatic void plan_run(input int t0, input int pc, input int lat[POP],
                                     input logic [FW-1:0] fit[POP],
                                     input logic [SE_W-1:0] se, input logic [IM_W-1:0] im);
        int n, s, w;
        logic [FW-1:0] best, f;
        logic [IW-1:0] bidx;
        n = (pc > POP) ? POP : pc;
        best = ONES; bidx = '0; s = t0 + 1;
        p_best[s] = {bidx, best};
        p_err[s]  = 1'b0;
        if (n == 0) begin
            p_done[s] = 1'b1;
            return;
        end
        p_cfg[s] = {se, im};
        for (int i = 0; i < n; i++) begin
            w = (lat[i] == 0) ? 64 : lat[i];
            p_rd[s] = IW'(i);
            p_ind[s+2] = mem[i];
            p_issue[s+2] = 1'b1;
            for (int j = 0; j < w; j++) p_we[s+3+j] = 1'b1;
            if (lat[i] != 0) begin
                d_fit[s+2+lat[i]] = fit[i];
                f = fit[i];
            end else begin
                f = ONES;
                p_err[s+3+w] = 1'b1;
            end
            p_wr[s+3+w] = {IW'(i), f};
            if (f < best) begin
                best = f;
                bidx = IW'(i);
            end
            p_best[s+4+w] = {bidx, best};
            s = s + 4 + w;
        end
        for (int c = t0 + 1; c <= s; c++) p_busy[c] = 1'b1;
        p_done[s] = 1'b1;
    endfunction

    // Compare process: every cycle, #1 after the rising edge.
    always @(posedge clk_i) begin
        logic [IW+FW-1:0] wr;
        #1;
        if (p_cfg.exists(cyc)) {e_se, e_im} = p_cfg[cyc];
        if (p_best.exists(cyc)) {e_bidx, e_best} = p_best[cyc];
        if (p_err.exists(cyc)) e_err = p_err[cyc];
        if (p_ind.exists(cyc)) e_ind = p_ind[cyc];
        chk("rd_en", 64'(ind_rd_en_o), 64'(p_rd.exists(cyc) != 0));
        if (p_rd.exists(cyc)) chk("rd_addr", 64'(ind_rd_addr_o), 64'(p_rd[cyc]));
        chk("issue", 64'(eval_in_valid_o), 64'(p_issue.exists(cyc) != 0));
        chk("wr_en", 64'(fit_wr_en_o), 64'(p_wr.exists(cyc) != 0));
        if (p_wr.exists(cyc)) begin
            wr = p_wr[cyc];
            chk("wr_addr", 64'(fit_wr_addr_o), 64'(wr[IW+FW-1:FW]));
            chk("wr_data", 64'(fit_wr_data_o), 64'(wr[FW-1:0]));
        end
        chk("done", 64'(done_o), 64'(p_done.exists(cyc) != 0));
        chk("busy", 64'(busy_o), 64'(p_busy.exists(cyc) != 0));
        chk("best_fit", 64'(best_fit_o), 64'(e_best));
        chk("best_idx", 64'(best_idx_o), 64'(e_bidx));
        chk("err", 64'(err_o), 64'(e_err));
        chk("cfg_se", 64'(eval_self_energy_o), 64'(e_se));
        chk("cfg_im", 64'(eval_interact_o), 64'(e_im));
        chk("individual", 64'(eval_individual_o), 64'(e_ind));
    end

    // Environment: evaluator responses per plan, noise elsewhere, population memory.
    task automatic drive_cycle();
        if (d_fit.exists(cyc)) begin
            eval_out_valid_i = 1'b1;
            eval_fit_i = d_fit[cyc];
        end else begin
            eval_out_valid_i = !p_we.exists(cyc) && ($urandom_range(0, 3) == 0);
            eval_fit_i = FW'($urandom);
        end
        ind_rd_data_i = rd_pend ? mem[rd_a] : IND_W'({$urandom, $urandom});
        rd_pend = ind_rd_en_o;
        rd_a = ind_rd_addr_o;
        start_i = start_noise && ($urandom_range(0, 3) == 0);
        pop_count_i = CW'($urandom);
        self_energy_vec_i = SE_W'($urandom);
        interact_matrix_i = IM_W'({$urandom, $urandom});
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
        drive_cycle();
    endtask

    task automatic launch(input int pc, input int lat[POP], input logic [FW-1:0] fit[POP],
                          output int t0);
        logic [SE_W-1:0] se;
        logic [IM_W-1:0] im;
        t0 = cyc;
        for (int i = 0; i < POP; i++) mem[i] = IND_W'({$urandom, $urandom});
        se = SE_W'($urandom);
        im = IM_W'({$urandom, $urandom});
        plan_run(t0, pc, lat, fit, se, im);
        start_i = 1'b1;
        pop_count_i = CW'(pc);
        self_energy_vec_i = se;
        interact_matrix_i = im;
    endtask

    task automatic run(input int pc, input int lat[POP], input logic [FW-1:0] fit[POP],
                       input bit noisy, output int dlat, output int nwr,
                       output logic [IW-1:0] lwa, output logic [FW-1:0] lwd, output bit sawbusy);
        int t0;
        bit seen;
        launch(pc, lat, fit, t0);
        start_noise = noisy;
        seen = 0; dlat = -1; nwr = 0; sawbusy = 0; lwa = '0; lwd = '0;
        for (int k = 0; k < 700 && !seen; k++) begin
            tick();
            if (fit_wr_en_o) begin
                nwr++;
                lwa = fit_wr_addr_o;
                lwd = fit_wr_data_o;
            end
            if (busy_o) sawbusy = 1;
            if (done_o) begin
                seen = 1;
                dlat = cyc - t0;
            end
        end
        start_noise = 0;
        start_i = 1'b0;
        chk("done_seen", 64'(seen), 64'd1);
        repeat ($urandom_range(1, 3)) tick();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat[POP];
        logic [FW-1:0] fit[POP];
        int dlat, nwr, t0, pc;
        logic [IW-1:0] lwa;
        logic [FW-1:0] lwd;
        bit sb;

        repeat (3) tick();
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_best", 64'(best_fit_o), 64'h3ff);
        chk("rst_wr_en", 64'(fit_wr_en_o), 64'd0);
        rst_n = 1'b0;
        repeat (2) tick();

        // 40, 25, 30 with single-cycle evaluator latency.
        lat = '{1, 1, 1, 0, 0, 0, 0, 0};
        fit = '{40, 25, 30, 0, 0, 0, 0, 0};
        run(3, lat, fit, 0, dlat, nwr, lwa, lwd, sb);
        chk("t1_done_lat", 64'(dlat), 64'd16);
        chk("t1_writes", 64'(nwr), 64'd3);
        chk("t1_last_wr", 64'({lwa, lwd}), 64'({3'd2, 10'd30}));
        chk("t1_best_fit", 64'(best_fit_o), 64'd25);
        chk("t1_best_idx", 64'(best_idx_o), 64'd1);

        // Tie keeps the earliest index.
        lat = '{1, 2, 1, 0, 0, 0, 0, 0};
        fit = '{7, 7, 9, 0, 0, 0, 0, 0};
        run(3, lat, fit, 0, dlat, nwr, lwa, lwd, sb);
        chk("t2_best_fit", 64'(best_fit_o), 64'd7);
        chk("t2_best_idx", 64'(best_idx_o), 64'd0);

        // Empty run.
        run(0, lat, fit, 0, dlat, nwr, lwa, lwd, sb);
        chk("t3_done_lat", 64'(dlat), 64'd1);
        chk("t3_writes", 64'(nwr), 64'd0);
        chk("t3_busy_seen", 64'(sb), 64'd0);
        chk("t3_best_fit", 64'(best_fit_o), 64'h3ff);

        // Evaluator silent for individual 1: 5 + (4 + 64) cycles, then DONE.
        lat = '{1, 0, 0, 0, 0, 0, 0, 0};
        fit = '{100, 0, 0, 0, 0, 0, 0, 0};
        run(2, lat, fit, 0, dlat, nwr, lwa, lwd, sb);
        chk("t4_done_lat", 64'(dlat), 64'd74);
        chk("t4_last_wr", 64'({lwa, lwd}), 64'({3'd1, 10'h3ff}));
        chk("t4_err", 64'(err_o), 64'd1);
        chk("t4_best_fit", 64'(best_fit_o), 64'd100);

        // Clamped population with start pulses during the run.
        for (int i = 0; i < POP; i++) begin
            lat[i] = $urandom_range(1, 3);
            fit[i] = FW'($urandom);
        end
        run(12, lat, fit, 1, dlat, nwr, lwa, lwd, sb);
        chk("t5_writes", 64'(nwr), 64'd8);
        chk("t5_last_addr", 64'(lwa), 64'd7);

        // Reset while waiting on the evaluator.
        lat = '{0, 0, 0, 0, 0, 0, 0, 0};
        launch(2, lat, fit, t0);
        repeat (10) tick();
        rst_n = 1'b1;
        clear_plan();
        rd_pend = 0;
        e_best = ONES; e_bidx = '0; e_err = 1'b0; e_se = '0; e_im = '0; e_ind = '0;
        #1;
        chk("t6_busy", 64'(busy_o), 64'd0);
        chk("t6_wr_en", 64'(fit_wr_en_o), 64'd0);
        chk("t6_best_fit", 64'(best_fit_o), 64'h3ff);
        chk("t6_individual", 64'(eval_individual_o), 64'd0);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        lat = '{2, 0, 0, 0, 0, 0, 0, 0};
        fit = '{55, 0, 0, 0, 0, 0, 0, 0};
        run(1, lat, fit, 0, dlat, nwr, lwa, lwd, sb);
        chk("t6_done_lat", 64'(dlat), 64'd7);
        chk("t6_writes", 64'(nwr), 64'd1);
        chk("t6_best_fit_after", 64'(best_fit_o), 64'd55);

        // Random runs.
        for (int r = 0; r < 30; r++) begin
            pc = $urandom_range(1, 15);
            for (int i = 0; i < POP; i++) begin
                case ($urandom_range(0, 15))
                    0, 1:    lat[i] = 0;
                    2:       lat[i] = 64;
                    default: lat[i] = $urandom_range(1, 5);
                endcase
                fit[i] = ($urandom_range(0, 3) == 0) ? FW'($urandom_range(0, 3)) : FW'($urandom);
            end
            run(pc, lat, fit, $urandom_range(0, 1) == 1, dlat, nwr, lwa, lwd, sb);
            chk("rand_writes", 64'(nwr), 64'((pc > POP) ? POP : pc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fitness_eval_sched.md
Name: fitness_eval_sched

Overview:
- Sequences a population of lattice individuals through the single shared fitness evaluator, one individual at a time.
- Per run: latches the energy configuration, reads each individual from the population memory and issues it to the evaluator. It then waits for the evaluator's result and writes each fitness to the fitness memory.
- Tracks the minimum-energy individual across the run and signals completion to the GA top-level controller.

Parameters:
- NUM_PARTICLE_TYPE, 3, number of particle species
- DATA_WIDTH, 4, bits per lattice site / energy entry
- LATTICE_LENGTH, 11, sites per individual
- SELF_FIT_LENGTH, 10, fitness result width
- POP_SIZE, 8, maximum individuals per run
- IDX_WIDTH, 3, population index width (clog2 of POP_SIZE)
- TIMEOUT, 64, maximum cycles spent waiting for an evaluator result
- SE_W, NUM_PARTICLE_TYPE*DATA_WIDTH, derived
- IM_W, NUM_PARTICLE_TYPE**2*DATA_WIDTH, derived
- IND_W, LATTICE_LENGTH*DATA_WIDTH, derived

Ports:
- clk_i  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-high reset (1 = reset)
- start_i  in  1  run request, sampled in IDLE only
- pop_count_i  in  IDX_WIDTH+1  individuals in this run
- self_energy_vec_i  in  SE_W  configuration, latched on accepted start
- interact_matrix_i  in  IM_W  configuration, latched on accepted start
- ind_rd_en_o  out  1  population memory read strobe
- ind_rd_addr_o  out  IDX_WIDTH  population memory address
- ind_rd_data_i  in  IND_W  read data, valid exactly 1 cycle after the strobe
- eval_in_valid_o  out  1  one-cycle issue pulse to the evaluator
- eval_self_energy_o  out  SE_W  latched configuration
- eval_interact_o  out  IM_W  latched configuration
- eval_individual_o  out  IND_W  individual being evaluated
- eval_out_valid_i  in  1  evaluator result valid
- eval_fit_i  in  SELF_FIT_LENGTH  evaluator result
- fit_wr_en_o  out  1  fitness memory write strobe
- fit_wr_addr_o  out  IDX_WIDTH  fitness memory address
- fit_wr_data_o  out  SELF_FIT_LENGTH  fitness memory data
- best_fit_o  out  SELF_FIT_LENGTH  minimum fitness of the current/last run
- best_idx_o  out  IDX_WIDTH  index of the minimum-fitness individual
- busy_o  out  1  high from FETCH through DONE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky timeout flag for the current run

Behaviour:
- Reset, applied immediately even mid-run:
  - state=IDLE
  - all strobes, busy_o, done_o, err_o = 0
  - all addresses, configuration and individual registers = 0
  - best_fit_o = all ones; best_idx_o = 0
  - No memory write completes after reset asserts.
- States and transitions:
  - IDLE: on start_i with pop_count_i != 0:
    - latch configuration; count = min(pop_count_i, POP_SIZE)
    - idx = 0; best_fit = all ones; best_idx = 0; err = 0
    - go to FETCH
  - IDLE: on start_i with pop_count_i == 0: go to DONE; no reads or writes; best_fit_o = all ones.
  - FETCH: ind_rd_en_o = 1, ind_rd_addr_o = idx; go to WAIT_RD.
  - WAIT_RD: register ind_rd_data_i into the individual register; go to ISSUE.
  - ISSUE: eval_in_valid_o = 1 for exactly this cycle; clear the timer; go to WAIT_EVAL.
  - WAIT_EVAL, result path: if eval_out_valid_i, capture eval_fit_i and go to WRITE.
  - WAIT_EVAL, wait path: otherwise increment the timer.
  - WAIT_EVAL, timeout: when the timer reaches TIMEOUT-1 without a result, capture all ones, set err_o (sticky until next accepted start) and go to WRITE.
  - WRITE:
    - fit_wr_en_o = 1, addr = idx, data = captured fitness
    - if captured < best_fit (strict), update best_fit and best_idx; ties keep the earlier index
    - if idx == count-1, go to DONE; else idx++ and go to FETCH
  - DONE: done_o = 1 for one cycle; go to IDLE.
- Configuration and individual outputs:
  - eval_self_energy_o, eval_interact_o and eval_individual_o are registered.
  - They are stable from ISSUE until the next WAIT_RD.
  - Configuration is held after the run ends until the next accepted start.
- Ignored inputs:
  - start_i while busy_o = 1
  - eval_out_valid_i outside WAIT_EVAL, including late results after a timeout
- Throughput: 5 cycles per individual when the result arrives in the first WAIT_EVAL cycle; 4+k cycles when it arrives in the k-th WAIT_EVAL cycle.
- Output timing:
  - best_fit_o and best_idx_o update in the cycle after WRITE and are final when done_o pulses.
  - Both hold until the next accepted start.
- Arithmetic: unsigned fitness comparison; pop_count_i values above POP_SIZE are clamped to POP_SIZE.

Test Plan:
- Reset then start, pop_count=3, evaluator returns 40, 25, 30 one cycle after each issue:
  - three writes, addr 0/1/2, data 40/25/30
  - best_fit=25, best_idx=1
  - done_o pulses 16 cycles after start accepted
- Fitness 7, 7, 9: best_idx=0 (tie keeps the earliest index).
- Evaluator silent for individual 1 of 2: write addr 1 = 0x3FF after 64 WAIT_EVAL cycles; err_o=1; run completes.
- pop_count=0: done_o pulses on the cycle after start; no rd/wr strobes; busy_o stays 0.
- start_i pulsed mid-run, and pop_count=12: second start ignored; exactly 8 writes (clamped).
- rst_n asserted during WAIT_EVAL: all outputs reset asynchronously; a subsequent start with pop_count=1 completes normally.
